cbus_axi_bridge: RTL and testbench

Converts the single CBus request produced by the CBus arbiter into AXI4 burst transactions on the SoC memory port, and returns data and completion back on the CBus response. Sits directly downstream of the arbiter's `oreq`/`oresp` pair and is the only CBus slave in the core. It handles one transaction at a time; CBus allows no outstanding-request overlap.

---
 rtl/cbus_axi_bridge_if.sv | 91 +++++++++
 rtl/cbus_axi_bridge.sv | 169 ++++++++++++++++
 tb/tb_cbus_axi_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbus_axi_bridge_if.sv
// cbus_axi_bridge_if: bundles the CBus request/response pair and the five
// AXI4 channels seen by the CBus-to-AXI bridge.
// Modport "master" is the bridge itself: it receives CBus requests and acts
// as master on AXI. Modport "slave" is the environment around it: it drives
// CBus requests and plays the AXI memory slave.
interface cbus_axi_bridge_if #(
    parameter int ID_W = 4
);

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [3:0]  len;      // beats - 1
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    cbus_req_t   creq;
    cbus_resp_t  cresp;

    logic [63:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [ID_W-1:0] arid;
    logic            arvalid;
    logic            arready;

    logic [63:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [63:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [ID_W-1:0] awid;
    logic            awvalid;
    logic            awready;

    logic [63:0]     wdata;
    logic [7:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        input  creq,
        output cresp,
        output araddr, arlen, arsize, arburst, arid, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awid, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        output creq,
        input  cresp,
        input  araddr, arlen, arsize, arburst, arid, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awid, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/cbus_axi_bridge.sv
// cbus_axi_bridge: turns the single outstanding CBus request into one AXI4
// INCR burst and returns read data / write acceptance on the CBus response.
// Build macro CBUS_AXI_BRESP_WAIT_EN: when defined, write completion
// (cresp.last) waits for the AXI B response; when undefined, writes are
// posted and complete on the final W beat (B is still awaited before the
// next request is taken).
//
// Handshake rule on every AXI channel: a transfer happens in each cycle in
// which valid and ready are both high; valid is a pure decode of the state
// register, so it never depends on ready, and the payload stays stable while
// valid waits. CBus: cresp.ready marks one accepted/returned beat, cresp.last
// marks completion of the whole transaction.
module cbus_axi_bridge #(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic              clk,
    input  logic              reset,
    cbus_axi_bridge_if.master bus,
    output logic              bus_err,
    output logic [2:0]        dbg_state
);

`ifdef CBUS_AXI_BRESP_WAIT_EN
    localparam bit BRESP_WAIT = 1'b1;
`else
    localparam bit BRESP_WAIT = 1'b0;
`endif

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW   = 3'd3,
        S_W    = 3'd4,
        S_B    = 3'd5
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [63:0] addr_q;
    logic [2:0]  size_q;
    logic [3:0]  len_q;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        err_d;
    logic        final_beat;

    // The request is captured only in IDLE; the master holds creq steady for
    // the whole transaction, so a valid seen later is the same request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            len_q   <= '0;
            bus_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_err <= err_d;
            if (state_q == S_IDLE && bus.creq.valid) begin
                addr_q <= bus.creq.addr;
                size_q <= bus.creq.size;
                len_q  <= bus.creq.len;
            end
        end
    end

    // Address/control payload comes straight from the latched request; it is
    // only meaningful while the matching valid is high.
    assign bus.araddr  = addr_q;
    assign bus.arlen   = {4'b0000, len_q};
    assign bus.arsize  = size_q;
    assign bus.arburst = BURST_INCR;
    assign bus.arid    = AXI_ID;

    assign bus.awaddr  = addr_q;
    assign bus.awlen   = {4'b0000, len_q};
    assign bus.awsize  = size_q;
    assign bus.awburst = BURST_INCR;
    assign bus.awid    = AXI_ID;

    // Write data is forwarded from the live request; the master advances
    // data/strobe after each cresp.ready beat.
    assign bus.wdata   = bus.creq.data;
    assign bus.wstrb   = bus.creq.strobe;

    assign final_beat  = (cnt_q == len_q);
    assign dbg_state   = state_q;

    // Next-state, beat counter, channel valids/readies and CBus response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.wlast   = 1'b0;
        bus.rready  = 1'b0;
        bus.bready  = 1'b0;
        bus.cresp   = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.creq.valid) begin
                    state_d = bus.creq.is_write ? S_AW : S_AR;
                end
            end

            S_AR: begin
                bus.arvalid = 1'b1;
                if (bus.arready) begin
                    state_d = S_R;
                end
            end

            S_R: begin
                bus.rready       = 1'b1;
                bus.cresp.ready  = bus.rvalid;
                bus.cresp.last   = bus.rvalid & bus.rlast;
                bus.cresp.data   = bus.rdata;
                err_d            = bus.rvalid & (bus.rresp != 2'b00);
                if (bus.rvalid && bus.rlast) begin
                    state_d = S_IDLE;
                end
            end

            S_AW: begin
                bus.awvalid = 1'b1;
                if (bus.awready) begin
                    state_d = S_W;
                    cnt_d   = '0;
                end
            end

            S_W: begin
                bus.wvalid      = 1'b1;
                bus.wlast       = final_beat;
                bus.cresp.ready = bus.wready;
                bus.cresp.last  = bus.wready & final_beat & ~BRESP_WAIT;
                if (bus.wready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (final_beat) begin
                        state_d = S_B;
                    end
                end
            end

            S_B: begin
                bus.bready     = 1'b1;
                bus.cresp.last = bus.bvalid & BRESP_WAIT;
                err_d          = bus.bvalid & (bus.bresp != 2'b00);
                if (bus.bvalid) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// tb_cbus_axi_bridge: directed plus randomized transactions through the
// bridge; the bench plays both the CBus master and the AXI memory slave.
module tb_cbus_axi_bridge;

`ifdef CBUS_AXI_BRESP_WAIT_EN
    localparam bit BRESP_WAIT = 1'b1;
`else
    localparam bit BRESP_WAIT = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       bus_err;
    logic [2:0] dbg_state;

    cbus_axi_bridge_if #(.ID_W(4)) bus ();

    cbus_axi_bridge #(
        .ID_W   (4),
        .AXI_ID (4'd0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .bus_err   (bus_err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic        err_drv  = 1'b0;   // error response being handed over this cycle
    logic        err_exp  = 1'b0;   // bus_err expected this cycle
    logic [63:0] exp_q[$];          // read data expected on cresp
    logic [71:0] wexp_q[$];         // {strobe, data} expected on W
    logic [63:0] wd[16];
    logic [7:0]  ws[16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        err_exp = err_drv;
        err_drv = 1'b0;
    endtask

    task automatic chk_err();
        chk("bus_err", 64'(bus_err), 64'(err_exp));
    endtask

    function automatic logic [6:0] ctl_vec();
        return {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready,
                bus.cresp.ready, bus.cresp.last};
    endfunction

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk(tag, 64'(ctl_vec()), 64'd0);
        chk("idle_cresp_data", bus.cresp.data, 64'd0);
        chk_err();
        step();
    endtask

    task automatic fill_wdata(input logic [3:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            wd[i] = {$urandom, $urandom};
            ws[i] = 8'($urandom);
        end
    endtask

    // driver: CBus read + AXI slave behaviour for AR/R
    task automatic run_read(input logic [63:0] addr, input logic [2:0] size,
                            input logic [3:0] len, input int ar_delay,
                            input int err_beat, input int gap_lo, input int gap_hi);
        bus.creq.valid    = 1'b1;
        bus.creq.is_write = 1'b0;
        bus.creq.addr     = addr;
        bus.creq.size     = size;
        bus.creq.len      = len;
        bus.creq.data     = '0;
        bus.creq.strobe   = '0;
        @(negedge clk);
        chk("rd_accept_quiet", 64'(ctl_vec()), 64'd0);
        chk_err();
        step();
        for (int i = 0; i < ar_delay; i++) begin
            @(negedge clk);
            chk("arvalid_stall", 64'(bus.arvalid), 64'd1);
            chk("araddr_stall", bus.araddr, addr);
            chk("rd_ar_cresp", 64'({bus.cresp.ready, bus.cresp.last}), 64'd0);
            chk_err();
            step();
        end
        bus.arready = 1'b1;
        @(negedge clk);
        chk("arvalid", 64'(bus.arvalid), 64'd1);
        chk("awvalid_in_rd", 64'(bus.awvalid), 64'd0);
        chk("araddr", bus.araddr, addr);
        chk("arlen", 64'(bus.arlen), 64'(len));
        chk("arsize", 64'(bus.arsize), 64'(size));
        chk("arburst", 64'(bus.arburst), 64'd1);
        chk("arid", 64'(bus.arid), 64'd0);
        chk_err();
        step();
        bus.arready = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            int          gap;
            logic [63:0] d;
            gap = int'($urandom_range(gap_lo, gap_hi));
            d   = {$urandom, $urandom};
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("rready_gap", 64'(bus.rready), 64'd1);
                chk("rd_gap_cresp", 64'({bus.arvalid, bus.cresp.ready, bus.cresp.last}), 64'd0);
                chk_err();
                step();
            end
            exp_q.push_back(d);
            bus.rvalid = 1'b1;
            bus.rdata  = d;
            bus.rlast  = (b == int'(len));
            bus.rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            if (b == err_beat) err_drv = 1'b1;
            @(negedge clk);
            chk("rd_cresp_ready", 64'(bus.cresp.ready), 64'd1);
            chk("rd_cresp_data", bus.cresp.data, exp_q.pop_front());
            chk("rd_cresp_last", 64'(bus.cresp.last), 64'(b == int'(len)));
            chk_err();
            step();
            bus.rvalid = 1'b0;
            bus.rlast  = 1'b0;
            bus.rresp  = 2'b00;
            bus.rdata  = '0;
        end
        bus.creq.valid = 1'b0;
    endtask

    // driver: CBus write + AXI slave behaviour for AW/W/B; abort_beat >= 0
    // pulses reset while that W beat is pending
    task automatic run_write(input logic [63:0] addr, input logic [3:0] len,
                             input int aw_delay, input int gap_lo, input int gap_hi,
                             input int b_delay, input logic [1:0] bresp,
                             input int abort_beat);
        int b;
        for (int i = 0; i <= int'(len); i++) wexp_q.push_back({ws[i], wd[i]});
        bus.creq.valid    = 1'b1;
        bus.creq.is_write = 1'b1;
        bus.creq.addr     = addr;
        bus.creq.size     = 3'd3;
        bus.creq.len      = len;
        bus.creq.data     = wd[0];
        bus.creq.strobe   = ws[0];
        @(negedge clk);
        chk("wr_accept_quiet", 64'(ctl_vec()), 64'd0);
        chk_err();
        step();
        for (int i = 0; i < aw_delay; i++) begin
            @(negedge clk);
            chk("awvalid_stall", 64'(bus.awvalid), 64'd1);
            chk("awaddr_stall", bus.awaddr, addr);
            chk_err();
            step();
        end
        bus.awready = 1'b1;
        @(negedge clk);
        chk("awvalid", 64'(bus.awvalid), 64'd1);
        chk("arvalid_in_wr", 64'(bus.arvalid), 64'd0);
        chk("awaddr", bus.awaddr, addr);
        chk("awlen", 64'(bus.awlen), 64'(len));
        chk("awsize", 64'(bus.awsize), 64'd3);
        chk("awburst", 64'(bus.awburst), 64'd1);
        chk("awid", 64'(bus.awid), 64'd0);
        chk("aw_cresp", 64'({bus.cresp.ready, bus.cresp.last}), 64'd0);
        chk_err();
        step();
        bus.awready = 1'b0;
        b = 0;
        while (b <= int'(len)) begin
            int gap;
            gap = int'($urandom_range(gap_lo, gap_hi));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("wvalid_gap", 64'(bus.wvalid), 64'd1);
                chk("wdata_gap", bus.wdata, wexp_q[0][63:0]);
                chk("wlast_gap", 64'(bus.wlast), 64'(b == int'(len)));
                chk("wr_gap_cresp", 64'({bus.cresp.ready, bus.cresp.last}), 64'd0);
                chk_err();
                step();
            end
            if (b == abort_beat) begin
                reset = 1'b0;
                @(negedge clk);
                chk("rst_sync_wvalid", 64'(bus.wvalid), 64'd1);
                step();
                @(negedge clk);
                chk("rst_quiet", 64'(ctl_vec()), 64'd0);
                chk("rst_cresp_data", bus.cresp.data, 64'd0);
                chk("rst_bus_err", 64'(bus_err), 64'd0);
                reset             = 1'b1;
                bus.creq.valid    = 1'b0;
                bus.creq.is_write = 1'b0;
                wexp_q.delete();
                step();
                return;
            end
            bus.wready = 1'b1;
            @(negedge clk);
            chk("wvalid", 64'(bus.wvalid), 64'd1);
            chk("wdata", bus.wdata, wexp_q[0][63:0]);
            chk("wstrb", 64'(bus.wstrb), 64'(wexp_q[0][71:64]));
            chk("wlast", 64'(bus.wlast), 64'(b == int'(len)));
            chk("wr_cresp_ready", 64'(bus.cresp.ready), 64'd1);
            chk("wr_cresp_last", 64'(bus.cresp.last), 64'((b == int'(len)) && !BRESP_WAIT));
            chk_err();
            void'(wexp_q.pop_front());
            step();
            bus.wready = 1'b0;
            b++;
            if (b <= int'(len)) begin
                bus.creq.data   = wd[b];
                bus.creq.strobe = ws[b];
            end else if (!BRESP_WAIT) begin
                bus.creq.valid = 1'b0;
            end
        end
        for (int i = 0; i < b_delay; i++) begin
            @(negedge clk);
            chk("bready_wait", 64'(bus.bready), 64'd1);
            chk("b_wait_quiet", 64'({bus.wvalid, bus.awvalid, bus.cresp.ready, bus.cresp.last}), 64'd0);
            chk_err();
            step();
        end
        bus.bvalid = 1'b1;
        bus.bresp  = bresp;
        if (bresp != 2'b00) err_drv = 1'b1;
        @(negedge clk);
        chk("bready", 64'(bus.bready), 64'd1);
        chk("b_cresp_last", 64'(bus.cresp.last), 64'(BRESP_WAIT));
        chk("b_cresp_ready", 64'(bus.cresp.ready), 64'd0);
        chk_err();
        step();
        bus.bvalid     = 1'b0;
        bus.bresp      = 2'b00;
        bus.creq.valid = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        bus.creq    = '0;
        bus.arready = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
        bus.rlast   = 1'b0;
        bus.rvalid  = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bresp   = 2'b00;
        bus.bvalid  = 1'b0;
        repeat (3) step();

        // reset state
        @(negedge clk);
        chk("reset_ctl", 64'(ctl_vec()), 64'd0);
        chk("reset_cresp_data", bus.cresp.data, 64'd0);
        chk("reset_bus_err", 64'(bus_err), 64'd0);
        reset = 1'b1;
        step();
        chk_idle("post_reset_idle");

        // 4-beat read, AR stalled 2 cycles, gaps in R
        run_read(64'h8000_0000, 3'd3, 4'd3, 2, -1, 0, 1);
        chk_idle("rd4_then_idle");

        // 2-beat write with fixed data/strobe, wready low one cycle per beat
        wd[0] = 64'h11; ws[0] = 8'hFF;
        wd[1] = 64'h22; ws[1] = 8'h0F;
        run_write(64'h8000_1000, 4'd1, 1, 1, 1, 1, 2'b00, -1);
        chk_idle("wr2_then_idle");

        // single-beat read, narrow size
        run_read(64'h0000_0000_1234_5670, 3'd2, 4'd0, 0, -1, 0, 0);
        chk_idle("rd1_then_idle");

        // error response on first of two beats
        run_read(64'h8000_2000, 3'd3, 4'd1, 1, 0, 0, 0);
        chk_idle("rderr_then_idle");

        // reset during second W beat of four, then a normal read
        fill_wdata(4'd3);
        run_write(64'h8000_3000, 4'd3, 0, 0, 0, 0, 2'b00, 1);
        run_read(64'h8000_4000, 3'd3, 4'd2, 0, -1, 0, 1);
        chk_idle("after_rst_rd_idle");

        // back-to-back read then write (awvalid two cycles after last R beat)
        run_read(64'h8000_5000, 3'd3, 4'd1, 0, -1, 0, 0);
        fill_wdata(4'd15);
        run_write(64'h8000_6000, 4'd15, 0, 0, 1, 0, 2'b10, -1);
        chk_idle("b2b_wr_idle");

        // randomized mix
        for (int t = 0; t < 14; t++) begin
            logic [3:0] len;
            int         eb;
            len = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(len))) : -1;
                run_read({32'h0, $urandom} & ~64'h7, 3'd3, len,
                         int'($urandom_range(0, 3)), eb, 0, 2);
            end else begin
                fill_wdata(len);
                run_write({32'h0, $urandom} & ~64'h7, len, int'($urandom_range(0, 3)),
                          0, 2, int'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00, -1);
            end
            if ($urandom_range(0, 1) == 1) chk_idle("rand_idle");
        end
        chk_idle("final_idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
